// File: rtl/mem_pkg.sv
// Shared definitions for the SRAM access unit and the EX/MEM stage that drives it.
//   OP_NONE / OP_RD / OP_WR : request codes on the op port (2'b11 is reserved, acts as none)
//   WAIT_CYCLES_DEFAULT     : default extra strobe cycles (strobe width = WAIT_CYCLES+1)
//   state_t                 : access sequencer states
package mem_pkg;

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_RD   = 2'b01;
    localparam logic [1:0] OP_WR   = 2'b10;

    localparam int unsigned WAIT_CYCLES_DEFAULT = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ACCESS,
        ST_WR_SETUP,
        ST_WR_PULSE,
        ST_WR_HOLD,
        ST_DONE
    } state_t;

endpackage

// File: rtl/mem_access.sv
// Asynchronous SRAM access sequencer for the pipeline MEM stage.
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   op, addr, wdata       : request (sampled only while idle)
//   rdata                 : last completed read data (registered)
//   busy                  : combinational stall request to the pipeline
//   done                  : one-cycle completion pulse (registered)
//   ram_addr, ram_dout    : SRAM address / write data, held for the whole access
//   ram_dout_en           : data-bus drive enable (tri-state resolved at top level)
//   ram_din               : SRAM read data
//   ram_en_n/oe_n/we_n    : active-low SRAM strobes, all registered
module mem_access
    import mem_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  op,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        busy,
    output logic        done,
    output logic [17:0] ram_addr,
    output logic [15:0] ram_dout,
    output logic        ram_dout_en,
    input  logic [15:0] ram_din,
    output logic        ram_en_n,
    output logic        ram_oe_n,
    output logic        ram_we_n
);

    localparam logic [2:0] WAIT_LOAD = 3'(WAIT_CYCLES);

    state_t     state;
    logic [2:0] wait_cnt;

    // Stall whenever an access is in flight, and already in the idle cycle
    // that accepts a request; the DONE cycle releases the pipeline.
    always_comb begin
        busy = 1'b0;
        if (state == ST_IDLE)
            busy = (op == OP_RD) || (op == OP_WR);
        else if (state != ST_DONE)
            busy = 1'b1;
    end

    // Strobes are set on the edge that enters a state, so every SRAM control
    // line is a flop output and reflects the state it is held in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            wait_cnt    <= '0;
            rdata       <= '0;
            done        <= 1'b0;
            ram_addr    <= '0;
            ram_dout    <= '0;
            ram_dout_en <= 1'b0;
            ram_en_n    <= 1'b1;
            ram_oe_n    <= 1'b1;
            ram_we_n    <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (op == OP_RD) begin
                        state    <= ST_RD_ACCESS;
                        ram_addr <= {2'b00, addr};
                        ram_dout <= wdata;
                        wait_cnt <= WAIT_LOAD;
                        ram_en_n <= 1'b0;
                        ram_oe_n <= 1'b0;
                    end else if (op == OP_WR) begin
                        state       <= ST_WR_SETUP;
                        ram_addr    <= {2'b00, addr};
                        ram_dout    <= wdata;
                        ram_en_n    <= 1'b0;
                        ram_dout_en <= 1'b1;
                    end
                end
                ST_RD_ACCESS: begin
                    if (wait_cnt == '0) begin
                        rdata    <= ram_din;
                        ram_en_n <= 1'b1;
                        ram_oe_n <= 1'b1;
                        done     <= 1'b1;
                        state    <= ST_DONE;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                ST_WR_SETUP: begin
                    state    <= ST_WR_PULSE;
                    wait_cnt <= WAIT_LOAD;
                    ram_we_n <= 1'b0;
                end
                ST_WR_PULSE: begin
                    if (wait_cnt == '0) begin
                        ram_we_n <= 1'b1;
                        state    <= ST_WR_HOLD;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                ST_WR_HOLD: begin
                    ram_en_n    <= 1'b1;
                    ram_dout_en <= 1'b0;
                    done        <= 1'b1;
                    state       <= ST_DONE;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: two instances (WAIT_CYCLES=1 and 0)
// share one request stream; each has its own SRAM array and a timeline
// model that predicts every output from the cycle offset since acceptance.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  op;
    logic [15:0] addr;
    logic [15:0] wdata;

    logic [15:0] rdata    [2];
    logic        busy     [2];
    logic        done     [2];
    logic [17:0] ram_addr [2];
    logic [15:0] ram_dout [2];
    logic        dout_en  [2];
    logic [15:0] ram_din  [2];
    logic        en_n     [2];
    logic        oe_n     [2];
    logic        we_n     [2];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_access #(.WAIT_CYCLES(1)) dut0 (
        .clk(clk), .rst(rst), .op(op), .addr(addr), .wdata(wdata),
        .rdata(rdata[0]), .busy(busy[0]), .done(done[0]),
        .ram_addr(ram_addr[0]), .ram_dout(ram_dout[0]), .ram_dout_en(dout_en[0]),
        .ram_din(ram_din[0]), .ram_en_n(en_n[0]), .ram_oe_n(oe_n[0]), .ram_we_n(we_n[0])
    );

    mem_access #(.WAIT_CYCLES(0)) dut1 (
        .clk(clk), .rst(rst), .op(op), .addr(addr), .wdata(wdata),
        .rdata(rdata[1]), .busy(busy[1]), .done(done[1]),
        .ram_addr(ram_addr[1]), .ram_dout(ram_dout[1]), .ram_dout_en(dout_en[1]),
        .ram_din(ram_din[1]), .ram_en_n(en_n[1]), .ram_oe_n(oe_n[1]), .ram_we_n(we_n[1])
    );

    function automatic int wait_of(input int i);
        return (i == 0) ? 1 : 0;
    endfunction

    function automatic logic [15:0] init_word(input int i, input int k);
        if (i == 0 && k == 3) return 16'hA5C3;
        return 16'((k * 16'h1111) ^ 16'h5A00 ^ (i << 3));
    endfunction

    // ---------------- SRAM arrays (16 words, low address bits) ----------------
    bit          preload = 1'b1;
    logic [15:0] sram [2][16];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (preload) begin
                for (int k = 0; k < 16; k++) sram[i][k] <= init_word(i, k);
            end else if (!en_n[i] && !we_n[i]) begin
                sram[i][ram_addr[i][3:0]] <= ram_dout[i];
            end
        end
    end

    assign ram_din[0] = sram[0][ram_addr[0][3:0]];
    assign ram_din[1] = sram[1][ram_addr[1][3:0]];

    // ---------------- behavioural model ----------------
    // act/t: access in flight and cycle offset since the accepting cycle (t=1
    // is the first access cycle). len = offset of the done cycle.
    bit          m_act   [2];
    bit          m_rd    [2];
    int          m_t     [2];
    logic [15:0] m_a     [2];
    logic [15:0] m_d     [2];
    logic [15:0] m_rdata [2];
    bit          m_fresh [2];
    logic [15:0] m_mem   [2][16];

    function automatic int len_of(input int i);
        return m_rd[i] ? 2 + wait_of(i) : 4 + wait_of(i);
    endfunction

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            for (int i = 0; i < 2; i++) begin
                if (preload)
                    for (int k = 0; k < 16; k++) m_mem[i][k] = init_word(i, k);
                if (rst) begin
                    m_act[i]   = 1'b0;
                    m_t[i]     = 0;
                    m_a[i]     = '0;
                    m_d[i]     = '0;
                    m_rdata[i] = '0;
                    m_fresh[i] = 1'b1;
                end else if (!m_act[i]) begin
                    if (op == 2'b01 || op == 2'b10) begin
                        m_act[i]   = 1'b1;
                        m_rd[i]    = (op == 2'b01);
                        m_t[i]     = 1;
                        m_a[i]     = addr;
                        m_d[i]     = wdata;
                        m_fresh[i] = 1'b0;
                    end
                end else begin
                    // SRAM array takes the data on the edge ending the first pulse cycle
                    if (!m_rd[i] && m_t[i] == 2) m_mem[i][m_a[i][3:0]] = m_d[i];
                    if (m_t[i] == len_of(i)) begin
                        m_act[i] = 1'b0;
                    end else begin
                        m_t[i] = m_t[i] + 1;
                        if (m_rd[i] && m_t[i] == len_of(i)) m_rdata[i] = m_mem[i][m_a[i][3:0]];
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input int i, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s[%0d] at %0t: got %h expected %h", nm, i, $time, got, exp);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    bit run = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (run) begin
                for (int i = 0; i < 2; i++) begin
                    int  w;
                    int  l;
                    bit  live;
                    bit  pulse;
                    w     = wait_of(i);
                    l     = len_of(i);
                    live  = m_act[i] && (m_t[i] < l);
                    pulse = m_act[i] && !m_rd[i] && (m_t[i] >= 2) && (m_t[i] <= 2 + w);
                    chk("busy", i, 32'(busy[i]),
                        32'(m_act[i] ? live : (op == 2'b01 || op == 2'b10)));
                    chk("done", i, 32'(done[i]), 32'(m_act[i] && m_t[i] == l));
                    chk("en_n", i, 32'(en_n[i]), 32'(!live));
                    chk("oe_n", i, 32'(oe_n[i]), 32'(!(live && m_rd[i])));
                    chk("we_n", i, 32'(we_n[i]), 32'(!pulse));
                    chk("dout_en", i, 32'(dout_en[i]), 32'(live && !m_rd[i]));
                    chk("ram_addr", i, 32'(ram_addr[i]), {14'd0, 2'b00, m_a[i]});
                    chk("rdata", i, 32'(rdata[i]), 32'(m_rdata[i]));
                    if (m_fresh[i] || (live && !m_rd[i]))
                        chk("ram_dout", i, 32'(ram_dout[i]), 32'(m_d[i]));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        op = 2'b00;
        repeat (n) next();
    endtask

    initial begin
        rst   = 1'b1;
        op    = 2'b00;
        addr  = '0;
        wdata = '0;
        repeat (3) next();
        preload = 1'b0;
        run     = 1'b1;
        @(negedge clk);
        chk("rst_rdata", 0, 32'(rdata[0]), 32'h0);
        chk("rst_en_n", 0, 32'(en_n[0]), 32'h1);
        chk("rst_ram_addr", 1, 32'(ram_addr[1]), 32'h0);
        chk("rst_done", 1, 32'(done[1]), 32'h0);
        next();
        rst = 1'b0;
        idle(3);

        // read, W=1, with inputs changed mid-access (instance 0)
        op = 2'b01; addr = 16'h0123;
        @(negedge clk);
        chk("rd_busy_c0", 0, 32'(busy[0]), 32'h1);
        next();
        @(negedge clk);
        chk("rd_addr_c1", 0, 32'(ram_addr[0]), 32'h00123);
        chk("rd_oe_c1", 0, 32'(oe_n[0]), 32'h0);
        #1 op = 2'b10; addr = 16'hFFFF;
        next();
        @(negedge clk);
        chk("rd_oe_c2", 0, 32'(oe_n[0]), 32'h0);
        chk("rd_we_c2", 0, 32'(we_n[0]), 32'h1);
        chk("rd_addr_c2", 0, 32'(ram_addr[0]), 32'h00123);
        chk("rd_busy_c2", 0, 32'(busy[0]), 32'h1);
        next();
        @(negedge clk);
        chk("rd_done_c3", 0, 32'(done[0]), 32'h1);
        chk("rd_rdata_c3", 0, 32'(rdata[0]), 32'hA5C3);
        chk("rd_oe_c3", 0, 32'(oe_n[0]), 32'h1);
        next();
        idle(10);

        // write, W=1 (instance 0)
        op = 2'b10; addr = 16'h8000; wdata = 16'h1234;
        for (int c = 0; c <= 6; c++) begin
            if (c == 6) op = 2'b00;
            @(negedge clk);
            chk("wr_we_n", 0, 32'(we_n[0]), 32'((c == 2 || c == 3) ? 1'b0 : 1'b1));
            chk("wr_dout_en", 0, 32'(dout_en[0]), 32'((c >= 1 && c <= 4) ? 1'b1 : 1'b0));
            chk("wr_done", 0, 32'(done[0]), 32'((c == 5) ? 1'b1 : 1'b0));
            if (c >= 1 && c <= 4) chk("wr_dout", 0, 32'(ram_dout[0]), 32'h1234);
            next();
        end
        idle(10);

        // back-to-back write then read, W=0 (instance 1)
        op = 2'b10; addr = 16'h0010; wdata = 16'hBEEF;
        for (int c = 0; c <= 8; c++) begin
            if (c == 5) begin op = 2'b01; addr = 16'h0010; end
            if (c == 8) op = 2'b00;
            @(negedge clk);
            if (c == 4) chk("b2b_wr_done", 1, 32'(done[1]), 32'h1);
            if (c == 5) chk("b2b_rd_accept", 1, 32'(busy[1]), 32'h1);
            if (c == 7) begin
                chk("b2b_rd_done", 1, 32'(done[1]), 32'h1);
                chk("b2b_rdata", 1, 32'(rdata[1]), 32'hBEEF);
            end
            next();
        end
        idle(10);

        // reset during the write pulse (instance 0)
        op = 2'b10; addr = 16'h0042; wdata = 16'h7777;
        next();
        next();
        #2 rst = 1'b1;
        #1;
        chk("rst_we_n", 0, 32'(we_n[0]), 32'h1);
        chk("rst_dout_en", 0, 32'(dout_en[0]), 32'h0);
        chk("rst_rdata_mid", 0, 32'(rdata[0]), 32'h0);
        chk("rst_addr_mid", 0, 32'(ram_addr[0]), 32'h0);
        next();
        rst = 1'b0;
        op  = 2'b00;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("rst_no_done", 0, 32'(done[0]), 32'h0);
            next();
        end

        // reserved / none requests
        op = 2'b11;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("rsv_busy", 0, 32'(busy[0]), 32'h0);
            chk("rsv_en_n", 1, 32'(en_n[1]), 32'h1);
            next();
        end
        idle(4);

        // randomized traffic with occasional asynchronous reset
        repeat (3000) begin
            int r;
            rst = 1'b0;
            r = $urandom_range(0, 9);
            op    = (r < 4) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
            addr  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : {12'h000, 4'($urandom)};
            wdata = 16'($urandom);
            if ($urandom_range(0, 399) == 0) #2 rst = 1'b1;
            next();
        end
        rst = 1'b0;
        idle(12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 1; it sets the extra cycles of each SRAM strobe (strobe width = WAIT_CYCLES+1 cycles, legal range 0..7).
REQ-002 SHALL have port clk  in  1  single clock; all state changes on posedge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port op  in  2  request code: 00 none, 01 read, 10 write, 11 reserved (treated as none).
REQ-005 SHALL have port addr  in  16  word address of the request.
REQ-006 SHALL have port wdata  in  16  write data.
REQ-007 SHALL have port rdata  out  16  last completed read data, registered.
REQ-008 SHALL have port busy  out  1  pipeline stall request, combinational.
REQ-009 SHALL have port done  out  1  one-cycle completion pulse, registered.
REQ-010 SHALL have port ram_addr  out  18  SRAM address = {2'b00, latched addr}.
REQ-011 SHALL have port ram_dout / ram_dout_en  out  16 / 1  write data and data-bus drive enable (tri-state resolved at top level).
REQ-012 SHALL have port ram_din  in  16  SRAM read data.
REQ-013 SHALL have port ram_en_n / ram_oe_n / ram_we_n  out  1 each  active-low chip enable, output enable, write enable.

Function
REQ-014 SHALL implement states IDLE, RD_ACCESS, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
REQ-015 SHALL accept a request only in IDLE: op=01 -> RD_ACCESS, op=10 -> WR_SETUP, else stay IDLE; addr/wdata latched on the accepting edge.
REQ-016 SHALL ignore op, addr, wdata in every state other than IDLE; requester holds op until done.
REQ-017 SHALL drive busy = 1 when (state != IDLE and state != DONE) or (state == IDLE and op in {01,10}); busy = 0 in DONE.
REQ-018 SHALL, for read accepted in IDLE cycle C: RD_ACCESS cycles C+1..C+1+W (ram_en_n=0, ram_oe_n=0, ram_we_n=1, ram_dout_en=0), capture ram_din into rdata on the edge ending RD_ACCESS, DONE in C+2+W.
REQ-019 SHALL, for write accepted in cycle C: WR_SETUP C+1 (en_n=0, dout_en=1, we_n=1), WR_PULSE C+2..C+2+W (we_n=0), WR_HOLD C+3+W (we_n=1, dout_en=1), DONE C+4+W.
REQ-020 SHALL hold ram_addr and ram_dout constant for the whole access; oe_n and we_n never low together.
REQ-021 SHALL deassert all strobes (en_n=oe_n=we_n=1, dout_en=0) in IDLE and DONE.
REQ-022 SHALL assert done for exactly the DONE cycle, then return to IDLE unconditionally; a new op is accepted no earlier than the following IDLE cycle.
REQ-023 SHALL hold rdata unchanged across writes and idle cycles; updated only by a completed read.
REQ-024 SHALL use a 3-bit wait counter, loaded with W on entry to RD_ACCESS/WR_PULSE, decrement to 0, no wrap; W=0 gives single-cycle strobes.
REQ-025 SHALL drive all SRAM control outputs from registers (glitch-free), not decoded combinationally from inputs.

Reset
REQ-026 SHALL on rst=1, immediately and regardless of clk: state=IDLE, rdata=0, done=0, ram_en_n=ram_oe_n=ram_we_n=1, ram_dout_en=0, ram_addr=0, ram_dout=0, counter=0.
REQ-027 SHALL abort any in-flight access on reset without completing it or pulsing done; first acceptance possible in the first IDLE cycle after rst falls.

Structure
REQ-028 SHALL place op encodings (OP_NONE/OP_RD/OP_WR), the state encoding and the WAIT_CYCLES default in shared package mem_pkg, reused by the EX/MEM stage.
REQ-029 SHALL be a single module; no sub-module is warranted.

Verification
REQ-030 Read, W=1: ram_din=16'hA5C3, op=01 addr=16'h0123 in cycle 0 -> ram_addr=18'h00123, oe_n low cycles 1-2, done and rdata=16'hA5C3 in cycle 3, busy high cycles 0-2.
REQ-031 Write, W=1: op=10 addr=16'h8000 wdata=16'h1234 -> we_n low cycles 2-3 only, dout_en high cycles 1-4, ram_dout=16'h1234 throughout, done in cycle 5.
REQ-032 W=0 back-to-back: write 16'hBEEF to 16'h0010 then read 16'h0010 with SRAM model -> write done cycle 4, read accepted cycle 5, rdata=16'hBEEF with done in cycle 7.
REQ-033 Input change mid-access: change addr to 16'hFFFF and op to 10 during RD_ACCESS -> ram_addr stays 18'h00123, access remains a read.
REQ-034 Reset mid-write: rst high during WR_PULSE -> we_n=1, dout_en=0 asynchronously, no done pulse, rdata=0.
REQ-035 Reserved/idle: op=11 or 00 for 10 cycles -> busy=0, all strobes inactive, state IDLE.
